// File: rtl/regfile.sv
// RISC-V integer register file: 32 x 32-bit, x0 hardwired to zero.
// Two combinational read ports with write-through bypass, one write port.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wEn,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] regs [0:31];
  logic        wr_live;
  logic        byp1;
  logic        byp2;

  // A write is live only when it will actually land at the next edge
  assign wr_live = wEn && !rst && (rd != 5'd0);
  assign byp1    = wr_live && (rs1 == rd);
  assign byp2    = wr_live && (rs2 == rd);

  // Storage update: reset wins over a write, writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_live) begin
      regs[rd] <= write_data;
    end
  end

  // Read port 1: x0 reads zero, in-flight write is forwarded
  always_comb begin
    read_data1 = regs[rs1];
    unique case (1'b1)
      (rs1 == 5'd0): read_data1 = 32'h0;
      byp1:          read_data1 = write_data;
      default:       read_data1 = regs[rs1];
    endcase
  end

  // Read port 2: same rules as port 1, fully independent
  always_comb begin
    read_data2 = regs[rs2];
    unique case (1'b1)
      (rs2 == 5'd0): read_data2 = 32'h0;
      byp2:          read_data2 = write_data;
      default:       read_data2 = regs[rs2];
    endcase
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile.
// Array reference model, directed scenarios plus random traffic.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        wEn;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int errors;
  int checks;
  logic [31:0] model [0:31];

  regfile dut (
    .clk        (clk),
    .rst        (rst),
    .wEn        (wEn),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, updating the model from the rules,
  // then return at the following falling edge for new stimulus.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wEn && rd != 5'd0) begin
      model[rd] = write_data;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wEn && !rst && rd != 5'd0 && a == rd) return write_data;
    return model[a];
  endfunction

  task automatic test_reset();
    rst = 1'b1; wEn = 1'b0; rd = 5'd0; write_data = 32'h0;
    rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      checks++;
      if (read_data1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1 x%0d got %h want 00000000", i, read_data1);
      end
      checks++;
      if (read_data2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 x%0d got %h want 00000000", 31 - i, read_data2);
      end
    end
  endtask

  task automatic test_write_sweep();
    logic [31:0] want [5];
    logic [4:0]  idx [5];
    for (int i = 1; i < 32; i++) begin
      wEn = 1'b1; rd = 5'(i);
      write_data = 32'(i * 64'h11111111);
      tick();
    end
    wEn = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(32 - i);
      #1;
      checks++;
      if (read_data1 !== model[i]) begin
        errors++;
        $display("FAIL sweep_rd1 x%0d got %h want %h", i, read_data1, model[i]);
      end
      checks++;
      if (read_data2 !== model[32 - i]) begin
        errors++;
        $display("FAIL sweep_rd2 x%0d got %h want %h",
                 32 - i, read_data2, model[32 - i]);
      end
    end
    idx[0] = 5'd1;  want[0] = 32'h11111111;
    idx[1] = 5'd2;  want[1] = 32'h22222222;
    idx[2] = 5'd15; want[2] = 32'hFFFFFFFF;
    idx[3] = 5'd16; want[3] = 32'h11111110;
    idx[4] = 5'd31; want[4] = 32'h1111110F;
    for (int k = 0; k < 5; k++) begin
      rs1 = idx[k];
      #1;
      checks++;
      if (read_data1 !== want[k]) begin
        errors++;
        $display("FAIL sweep_const x%0d got %h want %h",
                 idx[k], read_data1, want[k]);
      end
    end
  endtask

  task automatic test_dual_port();
    wEn = 1'b0; rs1 = 5'd1; rs2 = 5'd31;
    #1;
    checks++;
    if (read_data1 !== 32'h11111111 || read_data2 !== 32'h1111110F) begin
      errors++;
      $display("FAIL dual_port got %h/%h want 11111111/1111110f",
               read_data1, read_data2);
    end
  endtask

  task automatic test_x0();
    wEn = 1'b1; rd = 5'd0; write_data = 32'hDEADBEEF;
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass got %h/%h want 0/0", read_data1, read_data2);
    end
    tick();
    wEn = 1'b0;
    #1;
    checks++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_write got %h/%h want 0/0", read_data1, read_data2);
    end
    wEn = 1'b0; rd = 5'd5; write_data = 32'hCAFEBABE;
    tick();
    rs1 = 5'd5;
    #1;
    checks++;
    if (read_data1 !== 32'h55555555) begin
      errors++;
      $display("FAIL wen_off x5 got %h want 55555555", read_data1);
    end
  endtask

  task automatic test_bypass();
    wEn = 1'b1; rd = 5'd7; write_data = 32'h12345678;
    tick();
    wEn = 1'b1; rd = 5'd7; write_data = 32'hA5A5A5A5;
    rs1 = 5'd7; rs2 = 5'd7;
    #1;
    checks++;
    if (read_data1 !== 32'hA5A5A5A5 || read_data2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass got %h/%h want a5a5a5a5", read_data1, read_data2);
    end
    tick();
    wEn = 1'b0; write_data = 32'h0;
    #1;
    checks++;
    if (read_data1 !== 32'hA5A5A5A5 || read_data2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_hold got %h/%h want a5a5a5a5",
               read_data1, read_data2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      wEn = $urandom_range(0, 1);
      rd = 5'($urandom_range(0, 31));
      write_data = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (read_data1 !== expect_read(rs1)) begin
        errors++;
        $display("FAIL rand_rd1 n=%0d rs1=%0d got %h want %h",
                 n, rs1, read_data1, expect_read(rs1));
      end
      checks++;
      if (read_data2 !== expect_read(rs2)) begin
        errors++;
        $display("FAIL rand_rd2 n=%0d rs2=%0d got %h want %h",
                 n, rs2, read_data2, expect_read(rs2));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_priority();
    wEn = 1'b1; rd = 5'd3; write_data = 32'h33333333;
    tick();
    rst = 1'b1; wEn = 1'b1; rd = 5'd3; write_data = 32'hFFFFFFFF;
    rs1 = 5'd3; rs2 = 5'd7;
    #1;
    checks++;
    if (read_data1 !== 32'h33333333 || read_data2 !== model[7]) begin
      errors++;
      $display("FAIL pre_reset_read got %h/%h want 33333333/%h",
               read_data1, read_data2, model[7]);
    end
    tick();
    rst = 1'b0; wEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      checks++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_prio x%0d got %h/%h want 0",
                 i, read_data1, read_data2);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_write_sweep();
    test_dual_port();
    test_x0();
    test_bypass();
    test_random();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameters: none; all widths are fixed (32 registers, 32-bit data, 5-bit addresses).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wEn  input  1  write enable, sampled on rising clk.
REQ-006 rs1  input  5  read port 1 register index.
REQ-007 rs2  input  5  read port 2 register index.
REQ-008 rd  input  5  write port register index.
REQ-009 write_data  input  32  write port data.
REQ-010 read_data1  output  32  contents of register rs1.
REQ-011 read_data2  output  32  contents of register rs2.

Function
REQ-012 Storage SHALL be 32 registers x0..x31, each 32 bits, following RISC-V integer register file semantics.
REQ-013 x0 SHALL be hardwired to zero: reads of index 0 return 32'h00000000 on either port; writes to rd=0 are discarded.
REQ-014 Write: on rising clk with rst=0, wEn=1 and rd!=0, register[rd] SHALL take write_data; the new value is visible on the read ports immediately after that edge.
REQ-015 With wEn=0, no register SHALL change, regardless of rd or write_data.
REQ-016 Reads SHALL be combinational (zero latency); read_data1 and read_data2 follow rs1/rs2 and register contents within the same cycle, with no clock involvement.
REQ-017 The two read ports SHALL be fully independent; rs1 and rs2 may equal each other or any index, including rd.
REQ-018 Write-through bypass: when wEn=1, rst=0, rd!=0 and rsN==rd in the same cycle, read_dataN SHALL return write_data combinationally, before the edge; otherwise it returns the stored value.
REQ-019 Bypass SHALL be suppressed when rd=0 or rst=1; in those cases the read returns the stored value, or zero for x0.
REQ-020 Only one write per cycle; no write-collision handling is needed beyond REQ-018.
REQ-021 Outputs SHALL never be X or Z after the first reset edge, for any input combination.

Reset
REQ-022 On rising clk with rst=1, all registers x1..x31 SHALL be cleared to 32'h00000000.
REQ-023 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-024 Reset asserted mid-operation SHALL clear all state at the next rising edge; reads during that cycle still return pre-reset contents until the edge.
REQ-025 Before the first reset edge, register contents are undefined and SHALL NOT be relied on; x0 still reads zero.

Verification
REQ-026 Reset for one edge, then read x0..x31 on both ports -> all 32'h00000000.
REQ-027 Write xi = i*32'h11111111, truncated to 32 bits, for i=1..31, one write per cycle; then deassert wEn and sweep rs1=1..31 -> x1=11111111, x2=22222222, x15=FFFFFFFF, x16=11111110, x31=1111110F.
REQ-028 wEn=1, rd=0, write_data=DEADBEEF, then read rs1=rs2=0 -> 00000000; with wEn=0, rd=5, data=CAFEBABE -> x5 unchanged.
REQ-029 Bypass: x7 holds 12345678; drive wEn=1, rd=7, write_data=A5A5A5A5, rs1=7, rs2=7 before the edge -> both ports show A5A5A5A5 in that cycle, and the value persists after the edge.
REQ-030 Reset with simultaneous wEn=1, rd=3, data=FFFFFFFF -> after the edge x3=00000000 and all other registers are 00000000.
REQ-031 Dual-port read: rs1=1, rs2=31 after the REQ-027 writes -> read_data1=11111111, read_data2=1111110F in the same cycle.
